// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encodings,
// datapath widths and a saturating score helper.
package game_pkg;

   localparam int STATE_W  = 3;
   localparam int LEVEL_W  = 2;
   localparam int SCORE_W  = 16;
   localparam int X_W      = 10;
   localparam int LIVES_W  = 2;
   localparam int TIMER_W  = 9;
   localparam int BOOST_W  = 16;
   localparam int SCREEN_W = 640;

   // Game-flow states; the encoding is visible on the state output.
   localparam logic [STATE_W-1:0] ST_ATTRACT     = 3'd0;
   localparam logic [STATE_W-1:0] ST_READY       = 3'd1;
   localparam logic [STATE_W-1:0] ST_PLAYING     = 3'd2;
   localparam logic [STATE_W-1:0] ST_LEVEL_CLEAR = 3'd3;
   localparam logic [STATE_W-1:0] ST_WIN         = 3'd4;
   localparam logic [STATE_W-1:0] ST_GAME_OVER   = 3'd5;

   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   // Score increment that sticks at the maximum instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      if (v == SCORE_MAX) begin
         return v;
      end
      return v + {{(SCORE_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/game_state_controller_tick_timer.sv
// Frame-tick hold counter shared by READY, LEVEL_CLEAR, WIN and GAME_OVER.
// Counts on game ticks while enabled, clears on request, and flags when the
// count equals the terminal value selected by the caller.
module tick_timer
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_tick,
   input  logic               i_clear,
   input  logic               i_en,
   input  logic [TIMER_W-1:0] i_terminal,
   output logic               o_at_term
);

   logic [TIMER_W-1:0] r_count;

   // Counter: clear has priority over counting; nothing moves between ticks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_tick) begin
         if (i_clear) begin
            r_count <= '0;
         end else if (i_en) begin
            r_count <= r_count + {{(TIMER_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign o_at_term = (r_count == i_terminal);

endmodule

// File: rtl/game_state_controller.sv
// Game-flow master: sequences attract/ready/play/clear/win/game-over,
// keeps score and lives, and issues freeze, level and the one-tick
// speed-boost and level-restart pulses to the world logic.
// Optional build macro HIGH_SCORE_EN adds a persistent high-score register;
// without it high_score is tied to zero.
module game_state_controller
   import game_pkg::*;
#(
   parameter int START_LIVES   = 3,
   parameter int LAST_LEVEL    = 2,
   parameter int READY_TICKS   = 60,
   parameter int CLEAR_TICKS   = 90,
   parameter int END_TICKS     = 120,
   parameter int SCORE_STEP_PX = 16,
   parameter int BOOST_EVERY   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               game_tick,
   input  logic               any_input_level,
   input  logic               hit_lava_wall,
   input  logic               hit_hazard,
   input  logic               goal_reached,
   input  logic [X_W-1:0]     player_x,
   output logic [STATE_W-1:0] state,
   output logic [LEVEL_W-1:0] level,
   output logic               freeze,
   output logic               speed_boost_pulse,
   output logic               level_restart_pulse,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] high_score
);

   localparam logic [TIMER_W-1:0] READY_TERM = TIMER_W'(READY_TICKS - 1);
   localparam logic [TIMER_W-1:0] CLEAR_TERM = TIMER_W'(CLEAR_TICKS - 1);
   localparam logic [TIMER_W-1:0] END_TERM   = TIMER_W'(END_TICKS);
   localparam logic [BOOST_W-1:0] BOOST_LAST = BOOST_W'(BOOST_EVERY - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
   localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LAST_LEVEL);
   localparam logic [X_W:0]       STEP_WIDE  = (X_W+1)'(SCORE_STEP_PX);
   localparam logic [X_W-1:0]     STEP_X     = X_W'(SCORE_STEP_PX);

   // Registered game state
   logic [STATE_W-1:0] r_state;
   logic [LEVEL_W-1:0] r_level;
   logic [SCORE_W-1:0] r_score;
   logic [LIVES_W-1:0] r_lives;
   logic [X_W-1:0]     r_max_x;
   logic [BOOST_W-1:0] r_boost_cnt;
   logic               r_boost_pulse;
   logic               r_restart_pulse;

   // Next-state values
   logic [STATE_W-1:0] w_state_nxt;
   logic [LEVEL_W-1:0] w_level_nxt;
   logic [SCORE_W-1:0] w_score_nxt;
   logic [LIVES_W-1:0] w_lives_nxt;
   logic [X_W-1:0]     w_max_x_nxt;
   logic [BOOST_W-1:0] w_boost_cnt_nxt;
   logic               w_boost_pulse_nxt;
   logic               w_restart_pulse_nxt;

   // Timer control
   logic               w_timer_en;
   logic               w_timer_clr;
   logic               w_timer_at_term;
   logic [TIMER_W-1:0] w_timer_term;

   logic               w_hit;
   logic               w_new_ground;

   assign w_hit = hit_lava_wall | hit_hazard;

   // Compare one bit wider than the position so max_x+step never wraps.
   assign w_new_ground = ({1'b0, player_x} >= ({1'b0, r_max_x} + STEP_WIDE));

   // Terminal count for whichever state currently owns the timer.
   always_comb begin
      w_timer_term = END_TERM;
      case (r_state)
         ST_READY:       w_timer_term = READY_TERM;
         ST_LEVEL_CLEAR: w_timer_term = CLEAR_TERM;
         default:        w_timer_term = END_TERM;
      endcase
   end

   // Next-state and datapath decisions for one game tick.
   always_comb begin
      w_state_nxt         = r_state;
      w_level_nxt         = r_level;
      w_score_nxt         = r_score;
      w_lives_nxt         = r_lives;
      w_max_x_nxt         = r_max_x;
      w_boost_cnt_nxt     = r_boost_cnt;
      w_boost_pulse_nxt   = 1'b0;
      w_restart_pulse_nxt = 1'b0;
      w_timer_en          = 1'b0;

      case (r_state)
         ST_ATTRACT: begin
            if (any_input_level) begin
               w_state_nxt     = ST_READY;
               w_score_nxt     = '0;
               w_lives_nxt     = LIVES_INIT;
               w_level_nxt     = '0;
               w_max_x_nxt     = '0;
               w_boost_cnt_nxt = '0;
            end
         end

         ST_READY: begin
            w_timer_en = 1'b1;
            if (w_timer_at_term) begin
               w_state_nxt         = ST_PLAYING;
               w_restart_pulse_nxt = 1'b1;
            end
         end

         ST_PLAYING: begin
            if (w_hit) begin
               // max_x is kept so ground covered before the death scores nothing.
               if (r_lives == 2'd1) begin
                  w_state_nxt = ST_GAME_OVER;
                  w_lives_nxt = '0;
               end else begin
                  w_state_nxt = ST_READY;
                  w_lives_nxt = r_lives - 2'd1;
               end
            end else if (goal_reached) begin
               w_state_nxt = (r_level == LEVEL_LAST) ? ST_WIN : ST_LEVEL_CLEAR;
            end else if (w_new_ground) begin
               w_max_x_nxt = r_max_x + STEP_X;
               w_score_nxt = sat_inc(r_score);
               // Boost cadence keeps running even once the score is pinned.
               if (r_boost_cnt == BOOST_LAST) begin
                  w_boost_cnt_nxt   = '0;
                  w_boost_pulse_nxt = 1'b1;
               end else begin
                  w_boost_cnt_nxt = r_boost_cnt + {{(BOOST_W-1){1'b0}}, 1'b1};
               end
            end
         end

         ST_LEVEL_CLEAR: begin
            w_timer_en = 1'b1;
            if (w_timer_at_term) begin
               w_state_nxt = ST_READY;
               w_level_nxt = r_level + 2'd1;
               w_max_x_nxt = '0;
            end
         end

         ST_WIN, ST_GAME_OVER: begin
            // Timer parks at END_TICKS; input is only honoured once parked.
            if (w_timer_at_term) begin
               if (any_input_level) begin
                  w_state_nxt = ST_ATTRACT;
               end
            end else begin
               w_timer_en = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_ATTRACT;
         end
      endcase
   end

   assign w_timer_clr = (w_state_nxt != r_state);

   tick_timer u_tick_timer (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (game_tick),
      .i_clear    (w_timer_clr),
      .i_en       (w_timer_en),
      .i_terminal (w_timer_term),
      .o_at_term  (w_timer_at_term)
   );

   // Game registers: reset immediately, otherwise advance only on game ticks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= ST_ATTRACT;
         r_level         <= '0;
         r_score         <= '0;
         r_lives         <= LIVES_INIT;
         r_max_x         <= '0;
         r_boost_cnt     <= '0;
         r_boost_pulse   <= 1'b0;
         r_restart_pulse <= 1'b0;
      end else if (game_tick) begin
         r_state         <= w_state_nxt;
         r_level         <= w_level_nxt;
         r_score         <= w_score_nxt;
         r_lives         <= w_lives_nxt;
         r_max_x         <= w_max_x_nxt;
         r_boost_cnt     <= w_boost_cnt_nxt;
         r_boost_pulse   <= w_boost_pulse_nxt;
         r_restart_pulse <= w_restart_pulse_nxt;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] r_high_score;
   logic               w_hs_load;

   // Capture only on the tick that ends a game, and only if it is a new best.
   assign w_hs_load = (r_state == ST_PLAYING) &&
                      ((w_state_nxt == ST_WIN) || (w_state_nxt == ST_GAME_OVER)) &&
                      (r_score > r_high_score);

   // High score survives ATTRACT; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_high_score <= '0;
      end else if (game_tick && w_hs_load) begin
         r_high_score <= r_score;
      end
   end

   assign high_score = r_high_score;
`else
   assign high_score = '0;
`endif

   assign state               = r_state;
   assign level               = r_level;
   assign freeze              = (r_state != ST_PLAYING);
   assign speed_boost_pulse   = r_boost_pulse;
   assign level_restart_pulse = r_restart_pulse;
   assign score               = r_score;
   assign lives               = r_lives;

endmodule
